dna_read_ctrl: RTL and testbench

//  Sequencer for the Xilinx DNA_PORT primitive: generates the slow DNA clock,

---
 rtl/dna_read_ctrl.sv | 117 +++++++++++
 tb/tb_dna_read_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dna_read_ctrl.sv
// Read sequencer for the DNA_PORT primitive: divides clk down to dna_clk, drives
// READ/SHIFT and captures the device DNA MSB first, once after reset and on request.
module dna_read_ctrl #(
    parameter int DIV  = 4,
    parameter int DW   = 57,
    parameter bit AUTO = 1'b1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          dna_vld,
    output logic [DW-1:0] dna,
    output logic          dna_clk,
    output logic          dna_read,
    output logic          dna_shift,
    input  logic          dna_dout
);

    localparam int BW = $clog2(DW + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

    logic [1:0]    state;
    logic [7:0]    div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          auto_pend;
    logic          tick;

    assign tick = (div_cnt == DIV_LAST);

    // NOTE: every register here is non-blocking, so each branch below tests the
    // pre-edge dna_clk and bit_cnt, which is what makes the edge counting exact.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            auto_pend <= AUTO;
            busy      <= 1'b0;
            done      <= 1'b0;
            dna_vld   <= 1'b0;
            dna       <= '0;
            dna_clk   <= 1'b0;
            dna_read  <= 1'b0;
            dna_shift <= 1'b0;
        end else begin
            done <= 1'b0;

            // The divider only runs while a read is in flight.
            if (state == S_IDLE || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 8'd1;

            case (state)
                S_IDLE: begin
                    if (start || auto_pend) begin
                        state     <= S_LOAD;
                        auto_pend <= 1'b0;
                        busy      <= 1'b1;
                        dna_vld   <= 1'b0;
                        dna       <= '0;
                        dna_read  <= 1'b1;
                        dna_clk   <= 1'b0;
                        bit_cnt   <= '0;
                    end
                end

                S_LOAD: begin
                    if (tick) begin
                        dna_clk <= ~dna_clk;
                        // Falling edge after the single READ rising edge.
                        if (dna_clk) begin
                            state     <= S_SHIFT;
                            dna_read  <= 1'b0;
                            dna_shift <= 1'b1;
                        end
                    end
                end

                S_SHIFT: begin
                    if (tick) begin
                        if (!dna_clk) begin
                            dna     <= {dna[DW-2:0], dna_dout};
                            bit_cnt <= bit_cnt + 1'b1;
                            // Last bit is already on DOUT, so no further edge is issued.
                            if (bit_cnt == BIT_LAST) begin
                                state     <= S_DONE;
                                dna_shift <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                dna_vld   <= 1'b1;
                            end else begin
                                dna_clk <= 1'b1;
                            end
                        end else begin
                            dna_clk <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dna_read_ctrl.sv
// Directed bench for dna_read_ctrl: behavioural DNA_PORT models, scoreboard of
// expected DNA values, pin probes and latency checks for two configurations.
module tb_dna_read_ctrl;

    localparam logic [56:0] DNA_A = 57'h0823456789ABCDE;
    localparam logic [56:0] DNA_B = 57'h15A5A5A5A5A5A5A;

    logic        clk = 1'b0;
    logic        rstn_a, start_a, busy_a, done_a, vld_a, clk_a, read_a, shift_a, dout_a;
    logic [56:0] dna_a;
    logic        rstn_b, start_b, busy_b, done_b, vld_b, clk_b, read_b, shift_b, dout_b;
    logic [56:0] dna_b;

    always #5 clk = ~clk;

    dna_read_ctrl #(.DIV(4), .DW(57), .AUTO(1'b1)) u_dut_a (
        .clk(clk), .rstn(rstn_a), .start(start_a), .busy(busy_a), .done(done_a),
        .dna_vld(vld_a), .dna(dna_a), .dna_clk(clk_a), .dna_read(read_a),
        .dna_shift(shift_a), .dna_dout(dout_a)
    );

    dna_read_ctrl #(.DIV(2), .DW(57), .AUTO(1'b0)) u_dut_b (
        .clk(clk), .rstn(rstn_b), .start(start_b), .busy(busy_b), .done(done_b),
        .dna_vld(vld_b), .dna(dna_b), .dna_clk(clk_b), .dna_read(read_b),
        .dna_shift(shift_b), .dna_dout(dout_b)
    );

    // DNA_PORT models: READ rising edge loads, SHIFT rising edge shifts, DOUT is the MSB.
    logic [56:0] sr_a = '0;
    logic [56:0] sr_b = '0;
    always @(posedge clk_a) begin
        if (read_a)       sr_a <= DNA_A;
        else if (shift_a) sr_a <= {sr_a[55:0], 1'b0};
    end
    always @(posedge clk_b) begin
        if (read_b)       sr_b <= DNA_B;
        else if (shift_b) sr_b <= {sr_b[55:0], 1'b0};
    end
    assign dout_a = sr_a[56];
    assign dout_b = sr_b[56];

    // Pin probe on instance A.
    logic probe_rst;
    int   read_cyc, shift_rises, all_rises, period_bad, overlap, pcyc, last_rise;
    logic prev_clk;
    always @(negedge clk) begin
        if (probe_rst) begin
            read_cyc = 0; shift_rises = 0; all_rises = 0; period_bad = 0;
            overlap = 0; pcyc = 0; last_rise = -1; prev_clk = 1'b0;
        end else begin
            pcyc++;
            if (read_a) read_cyc++;
            if (read_a && shift_a) overlap++;
            if (clk_a && !prev_clk) begin
                all_rises++;
                if (shift_a) shift_rises++;
                if (last_rise >= 0 && (pcyc - last_rise) != 8) period_bad++;
                last_rise = pcyc;
            end
            prev_clk = clk_a;
        end
    end

    logic [56:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    // Called at the negedge following the edge that accepted the read.
    task automatic wait_done(input bit sel, input int limit, output int lat);
        lat = 0;
        while (!get_done(sel) && lat < limit) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", {63'd0, get_done(sel)}, 64'd1);
    endtask

    task automatic check_dna(input string tag, input logic [56:0] obs);
        logic [56:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check(tag, {7'd0, obs}, {7'd0, exp});
    endtask

    int lat, n, dones, done_at;

    initial begin
        rstn_a = 1'b0; start_a = 1'b0;
        rstn_b = 1'b0; start_b = 1'b0;
        probe_rst = 1'b1;
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("rst_ctl", {58'd0, busy_a, done_a, vld_a, clk_a, read_a, shift_a}, 64'd0);
        check("rst_dna", {7'd0, dna_a}, 64'd0);

        // Automatic read after reset release, with pin probing.
        exp_q.push_back(DNA_A);
        probe_rst = 1'b0;
        rstn_a    = 1'b1;
        @(negedge clk);
        check("auto_busy", {63'd0, busy_a}, 64'd1);
        check("auto_read", {63'd0, read_a}, 64'd1);
        wait_done(1'b0, 600, lat);
        check("auto_lat", 64'(lat), 64'd460);
        check_dna("auto_dna", dna_a);
        check("auto_vld", {63'd0, vld_a}, 64'd1);
        check("probe_read_cyc", 64'(read_cyc), 64'd8);
        check("probe_shift_rises", 64'(shift_rises), 64'd56);
        check("probe_all_rises", 64'(all_rises), 64'd57);
        check("probe_period", 64'(period_bad), 64'd0);
        check("probe_overlap", 64'(overlap), 64'd0);
        @(negedge clk);
        check("done_pulse", {62'd0, done_a, busy_a}, 64'd0);
        check("vld_hold", {63'd0, vld_a}, 64'd1);
        probe_rst = 1'b1;

        // Software re-read.
        repeat (4) @(negedge clk);
        exp_q.push_back(DNA_A);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("reread_clear", {5'd0, vld_a, dna_a, busy_a}, 64'd1);
        wait_done(1'b0, 600, lat);
        check("reread_lat", 64'(lat), 64'd460);
        check_dna("reread_dna", dna_a);

        // Starts while busy (and in the DONE cycle) are dropped.
        repeat (3) @(negedge clk);
        exp_q.push_back(DNA_A);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0; dones = 0; done_at = -1;
        while (n < 475) begin
            @(negedge clk);
            n++;
            if (done_a) begin
                dones++;
                done_at = n;
                check_dna("busy_start_dna", dna_a);
            end
            start_a = (n == 9 || n == 199 || n == 459 || n == 460);
        end
        start_a = 1'b0;
        check("busy_start_dones", 64'(dones), 64'd1);
        check("busy_start_lat", 64'(done_at), 64'd460);
        check("busy_start_idle", {62'd0, busy_a, read_a}, 64'd0);
        check("busy_start_vld", {63'd0, vld_a}, 64'd1);

        // Reset in the middle of SHIFT aborts; AUTO restarts afterwards.
        exp_q.push_back(DNA_A);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (299) @(negedge clk);
        check("mid_shift_busy", {62'd0, busy_a, shift_a}, 64'd3);
        rstn_a = 1'b0;
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_ctl", {58'd0, busy_a, done_a, vld_a, clk_a, read_a, shift_a}, 64'd0);
            check("midrst_dna", {7'd0, dna_a}, 64'd0);
        end
        exp_q.push_back(DNA_A);
        rstn_a = 1'b1;
        @(negedge clk);
        check("midrst_auto_busy", {63'd0, busy_a}, 64'd1);
        wait_done(1'b0, 600, lat);
        check("midrst_lat", 64'(lat), 64'd460);
        check_dna("midrst_dna_val", dna_a);

        // DIV=2, AUTO=0: idle until start.
        rstn_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_idle", {59'd0, busy_b, done_b, clk_b, read_b, shift_b}, 64'd0);
        end
        exp_q.push_back(DNA_B);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_busy", {62'd0, busy_b, read_b}, 64'd3);
        wait_done(1'b1, 300, lat);
        check("b_lat", 64'(lat), 64'd230);
        check_dna("b_dna", dna_b);
        check("b_vld", {63'd0, vld_b}, 64'd1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
